modexp_controller: RTL and testbench
====================================

Name: modexp_controller

Overview:
- Initiator-side sequencer that drives the Montgomery multiplier's start/done handshake to compute a modular exponentiation X^E mod M.
- Uses left-to-right square-and-multiply in the Montgomery domain; the exponentiation itself performs no arithmetic.
- Converts X into the Montgomery domain, runs the exponent loop, and converts the result back out.
- Sits above one montgomery instance. Its mont_* ports connect one-to-one to that instance's start, in_a, in_b, in_m, result and done.

Parameters:
- WIDTH, 1024: operand width; the Montgomery constant is R = 2^WIDTH.
- EXP_WIDTH, 1024: maximum exponent width.
- LEN_W, 11: width of the exponent-length field; must satisfy 2^LEN_W > EXP_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_x  in  WIDTH  base, with X < M.
- in_e  in  EXP_WIDTH  exponent; bit 0 is the LSB.
- in_e_len  in  LEN_W  number of significant exponent bits, range 0..EXP_WIDTH.
- in_m  in  WIDTH  odd modulus.
- in_r  in  WIDTH  R mod M.
- in_r2  in  WIDTH  R^2 mod M.
- mont_start  out  1  one-cycle launch pulse to the multiplier.
- mont_a  out  WIDTH  multiplier operand A.
- mont_b  out  WIDTH  multiplier operand B.
- mont_m  out  WIDTH  modulus to the multiplier.
- mont_result  in  WIDTH  multiplier result.
- mont_done  in  1  multiplier completion flag.
- result  out  WIDTH  X^E mod M.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all registers and outputs are 0, including mont_start, done, result, mont_a, mont_b and mont_m. The state is IDLE.
- Reset asserted mid-operation aborts immediately. The multiplier result of any operation in flight is discarded.
- Start acceptance: in IDLE, start=1 latches in_x, in_e, in_e_len, in_m and in_r2 into internal registers. In the same cycle, acc is loaded with in_r.
  - Inputs may change after the start cycle.
  - start is ignored in every non-IDLE state.
- States and transitions:
  - IDLE -> TOMONT.
  - TOMONT: issue (xm = Mont(x, r2)) -> LOOPCHK.
  - LOOPCHK: if bit counter = 0 -> FROMMONT; else decrement the counter and go to SQUARE.
  - SQUARE: issue (acc = Mont(acc, acc)). If the exponent bit at the counter index is 1 -> MULT; else -> LOOPCHK.
  - MULT: issue (acc = Mont(acc, xm)) -> LOOPCHK.
  - FROMMONT: issue (acc = Mont(acc, 1)) -> FIN.
  - FIN: result <= acc, done=1 for one cycle -> IDLE.
- Each issue uses a shared WAIT sub-state with a return-state register:
  - Cycle 0: drive mont_a, mont_b and mont_m; pulse mont_start=1.
  - mont_a, mont_b and mont_m stay stable until completion, because the multiplier reads them throughout the operation.
  - mont_done is ignored in cycle 0 and cycle 1 after mont_start, so a stale high from the previous operation is not taken as completion.
  - The first high sample in cycle 2 or later captures mont_result into the destination register (xm or acc). The next cycle proceeds.
- Exponent scan runs MSB first, starting at bit in_e_len-1.
  - Bits at index in_e_len or above are never examined.
  - in_e_len > EXP_WIDTH is clamped to EXP_WIDTH.
- in_e_len = 0 skips the loop. The result is then Mont(R mod M, 1) = 1 mod M, after exactly 2 multiplier operations.
- Operation count = 2 + in_e_len + popcount(in_e[in_e_len-1:0]).
- done is asserted only in FIN. result holds its value until the next FIN.
- There is no stall or timeout. A multiplier that never asserts mont_done hangs the block until reset.

Decomposition:
- Shared package modexp_pkg holds:
  - the state encoding (IDLE, TOMONT, LOOPCHK, SQUARE, MULT, FROMMONT, FIN, WAIT);
  - the operand-select constants (SEL_X_R2, SEL_ACC_ACC, SEL_ACC_XM, SEL_ACC_ONE);
  - the done-blanking constant, value 2.
- One sub-module, modexp_exp_scanner:
  - holds the exponent register and the down-counter;
  - outputs the current bit and a zero flag;
  - loads on start and steps on decrement.

Test Plan:
- Bench setup: WIDTH=16, with a behavioural Montgomery model (R = 2^16) of random latency 3-40 cycles.
- M=241, X=2, E=5, len=3 -> result=32. Exactly 7 mont_start pulses; done pulses once.
- M=241, X=7, E=0, len=0 -> result=1 after exactly 2 operations.
- Model holds mont_done high from the previous operation for 2 cycles after the new mont_start. No premature capture occurs, and the result stays correct (M=65521, X=3, E=0xFFFF, len=16 -> golden pow).
- start pulsed repeatedly mid-run -> ignored. The result and operation count equal those of an undisturbed run, and mont_a/mont_b stay stable between mont_start and capture.
- reset asserted during the 4th operation -> all outputs 0 in that cycle, state IDLE. A new start (X=2, E=5, M=241) completes with result 32.
- in_e=0x13 with len=3 -> only bits 2..0 are used (E=3) -> result 8 for X=2, M=241.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
package modexp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StToMont,
    StLoopChk,
    StSquare,
    StMult,
    StFromMont,
    StFin,
    StWait
  } state_e;

  typedef enum logic [1:0] {
    SelXR2,
    SelAccAcc,
    SelAccXm,
    SelAccOne
  } opsel_e;

  // Cycles after mont_start during which mont_done may still be stale.
  localparam int unsigned DoneBlank = 2;

endpackage

// File: rtl/modexp_exp_scanner.sv
// Exponent register plus MSB-first bit down-counter for the square-and-multiply loop.
module modexp_exp_scanner #(
  parameter int unsigned EXP_WIDTH = 1024,
  parameter int unsigned LEN_W     = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 dec_i,
  input  logic [EXP_WIDTH-1:0] e_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 bit_o,
  output logic                 zero_o
);

  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [EXP_WIDTH-1:0] e_shift;

  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (load_i) begin
      e_d   = e_i;
      cnt_d = (len_i > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : len_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  // Shift rather than index so a counter equal to EXP_WIDTH never selects out of range.
  assign e_shift = e_q >> cnt_q;
  assign bit_o   = e_shift[0];
  assign zero_o  = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/modexp_controller.sv
// Sequences a Montgomery multiplier through X^E mod M using left-to-right square-and-multiply.
module modexp_controller
  import modexp_pkg::*;
#(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024,
  parameter int unsigned LEN_W     = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_e_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic                 mont_start,
  output logic [WIDTH-1:0]     mont_a,
  output logic [WIDTH-1:0]     mont_b,
  output logic [WIDTH-1:0]     mont_m,
  input  logic [WIDTH-1:0]     mont_result,
  input  logic                 mont_done,
  output logic [WIDTH-1:0]     result,
  output logic                 done
);

  state_e           state_q, state_d, ret_q, ret_d;
  logic [1:0]       wcnt_q, wcnt_d;
  logic             dst_xm_q, dst_xm_d;
  logic [WIDTH-1:0] x_q, x_d, m_q, m_d, r2_q, r2_d;
  logic [WIDTH-1:0] acc_q, acc_d, xm_q, xm_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d, mont_start_q, mont_start_d;
  logic [WIDTH-1:0] mont_a_q, mont_a_d, mont_b_q, mont_b_d, mont_m_q, mont_m_d;

  logic             issue, scan_load, scan_dec, scan_bit, scan_zero;
  opsel_e           sel;
  logic [WIDTH-1:0] op_a, op_b;

  modexp_exp_scanner #(
    .EXP_WIDTH(EXP_WIDTH),
    .LEN_W    (LEN_W)
  ) u_scanner (
    .clk_i (clk),
    .rst_i (reset),
    .load_i(scan_load),
    .dec_i (scan_dec),
    .e_i   (in_e),
    .len_i (in_e_len),
    .bit_o (scan_bit),
    .zero_o(scan_zero)
  );

  always_comb begin
    op_a = acc_q;
    op_b = acc_q;
    unique case (sel)
      SelXR2:    begin op_a = x_q;   op_b = r2_q;          end
      SelAccAcc: begin op_a = acc_q; op_b = acc_q;         end
      SelAccXm:  begin op_a = acc_q; op_b = xm_q;          end
      SelAccOne: begin op_a = acc_q; op_b = WIDTH'(1);     end
      default:   begin op_a = acc_q; op_b = acc_q;         end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    wcnt_d       = wcnt_q;
    dst_xm_d     = dst_xm_q;
    x_d          = x_q;
    m_d          = m_q;
    r2_d         = r2_q;
    acc_d        = acc_q;
    xm_d         = xm_q;
    result_d     = result_q;
    done_d       = 1'b0;
    mont_start_d = 1'b0;
    mont_a_d     = mont_a_q;
    mont_b_d     = mont_b_q;
    mont_m_d     = mont_m_q;
    issue        = 1'b0;
    sel          = SelAccAcc;
    scan_load    = 1'b0;
    scan_dec     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d       = in_x;
          m_d       = in_m;
          r2_d      = in_r2;
          acc_d     = in_r;
          scan_load = 1'b1;
          state_d   = StToMont;
        end
      end
      StToMont: begin
        issue    = 1'b1;
        sel      = SelXR2;
        dst_xm_d = 1'b1;
        ret_d    = StLoopChk;
      end
      StLoopChk: begin
        if (scan_zero) begin
          state_d = StFromMont;
        end else begin
          scan_dec = 1'b1;
          state_d  = StSquare;
        end
      end
      StSquare: begin
        issue    = 1'b1;
        sel      = SelAccAcc;
        dst_xm_d = 1'b0;
        ret_d    = scan_bit ? StMult : StLoopChk;
      end
      StMult: begin
        issue    = 1'b1;
        sel      = SelAccXm;
        dst_xm_d = 1'b0;
        ret_d    = StLoopChk;
      end
      StFromMont: begin
        issue    = 1'b1;
        sel      = SelAccOne;
        dst_xm_d = 1'b0;
        ret_d    = StFin;
      end
      StFin: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      StWait: begin
        // mont_done is blanked for the first DoneBlank cycles to skip a stale completion.
        if (wcnt_q < 2'(DoneBlank)) begin
          wcnt_d = wcnt_q + 2'd1;
        end else if (mont_done) begin
          if (dst_xm_q) xm_d = mont_result;
          else          acc_d = mont_result;
          state_d = ret_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      mont_a_d     = op_a;
      mont_b_d     = op_b;
      mont_m_d     = m_q;
      mont_start_d = 1'b1;
      wcnt_d       = 2'd0;
      state_d      = StWait;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ret_q        <= StIdle;
      wcnt_q       <= '0;
      dst_xm_q     <= 1'b0;
      x_q          <= '0;
      m_q          <= '0;
      r2_q         <= '0;
      acc_q        <= '0;
      xm_q         <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      mont_start_q <= 1'b0;
      mont_a_q     <= '0;
      mont_b_q     <= '0;
      mont_m_q     <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      wcnt_q       <= wcnt_d;
      dst_xm_q     <= dst_xm_d;
      x_q          <= x_d;
      m_q          <= m_d;
      r2_q         <= r2_d;
      acc_q        <= acc_d;
      xm_q         <= xm_d;
      result_q     <= result_d;
      done_q       <= done_d;
      mont_start_q <= mont_start_d;
      mont_a_q     <= mont_a_d;
      mont_b_q     <= mont_b_d;
      mont_m_q     <= mont_m_d;
    end
  end

  assign mont_start = mont_start_q;
  assign mont_a     = mont_a_q;
  assign mont_b     = mont_b_q;
  assign mont_m     = mont_m_q;
  assign result     = result_q;
  assign done       = done_q;

endmodule

// File: tb/tb_modexp_controller.sv
// Bench for modexp_controller: behavioural Montgomery multiplier with random latency and
// an arithmetic modular-power reference.
module tb_modexp_controller;
  import modexp_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned EW = 16;
  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] in_e_len = '0;
  logic          mont_start, done;
  logic [W-1:0]  mont_a, mont_b, mont_m, result;
  logic [W-1:0]  mont_result = '0;
  logic          mont_done = 1'b0;

  int tests = 0;
  int fails = 0;
  int op_cnt = 0;
  bit stale_mode = 1'b0;

  modexp_controller #(
    .WIDTH    (W),
    .EXP_WIDTH(EW),
    .LEN_W    (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_x       (in_x),
    .in_e       (in_e),
    .in_e_len   (in_e_len),
    .in_m       (in_m),
    .in_r       (in_r),
    .in_r2      (in_r2),
    .mont_start (mont_start),
    .mont_a     (mont_a),
    .mont_b     (mont_b),
    .mont_m     (mont_m),
    .mont_result(mont_result),
    .mont_done  (mont_done),
    .result     (result),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // a*b*2^-W mod m by repeated halving.
  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
    longint unsigned t;
    t = 64'(a) * 64'(b);
    for (int i = 0; i < W; i++) begin
      if (t[0]) t = t + 64'(m);
      t = t >> 1;
    end
    if (t >= 64'(m)) t = t - 64'(m);
    return t[W-1:0];
  endfunction

  // Right-to-left binary power over the low len bits of e.
  function automatic logic [W-1:0] pow_ref(input logic [W-1:0] x, input logic [EW-1:0] e,
                                           input int len, input logic [W-1:0] m);
    longint unsigned r, b;
    r = 64'(1) % 64'(m);
    b = 64'(x) % 64'(m);
    for (int i = 0; i < len; i++) begin
      if (e[i]) r = (r * b) % 64'(m);
      b = (b * b) % 64'(m);
    end
    return r[W-1:0];
  endfunction

  // Behavioural multiplier; optionally leaves the previous done high for two cycles.
  logic [W-1:0] cap_a, cap_b, cap_m, res_pend;
  int  lat, elapsed;
  bit  busy = 1'b0;
  bit  stale = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      busy      = 1'b0;
      mont_done = 1'b0;
    end else if (mont_start) begin
      op_cnt++;
      cap_a    = mont_a;
      cap_b    = mont_b;
      cap_m    = mont_m;
      res_pend = mont_ref(mont_a, mont_b, mont_m);
      lat      = int'($urandom_range(3, 40));
      elapsed  = 0;
      busy     = 1'b1;
      stale    = stale_mode && mont_done;
      if (!stale) begin
        mont_done   = 1'b0;
        mont_result = ~res_pend;
      end
    end else if (busy) begin
      elapsed++;
      chk("operands stable", {mont_a, mont_b}, {cap_a, cap_b});
      chk("modulus stable", 32'(mont_m), 32'(cap_m));
      if (elapsed == 2 && stale) begin
        mont_done   = 1'b0;
        mont_result = ~res_pend;
      end
      if (elapsed >= lat) begin
        mont_done   = 1'b1;
        mont_result = res_pend;
        busy        = 1'b0;
      end
    end
  end

  task automatic load_inputs(input logic [W-1:0] x, input logic [EW-1:0] e, input int len,
                             input logic [W-1:0] m);
    longint unsigned r;
    r        = 64'h1_0000 % 64'(m);
    in_x     = x;
    in_e     = e;
    in_e_len = LW'(len);
    in_m     = m;
    in_r     = r[W-1:0];
    r        = (r * r) % 64'(m);
    in_r2    = r[W-1:0];
  endtask

  task automatic run_exp(input string tag, input logic [W-1:0] x, input logic [EW-1:0] e,
                         input int len, input logic [W-1:0] m, input bit disturb);
    int eff, exp_ops, cyc;
    bit seen;
    logic [W-1:0] exp_res;
    eff     = (len > int'(EW)) ? int'(EW) : len;
    exp_res = pow_ref(x, e, eff, m);
    exp_ops = 2 + eff;
    for (int i = 0; i < eff; i++) exp_ops += int'(e[i]);

    @(negedge clk);
    op_cnt = 0;
    load_inputs(x, e, len, m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_x  = W'($urandom);
    in_e  = EW'($urandom);
    in_m  = W'($urandom);
    in_r  = W'($urandom);
    in_r2 = W'($urandom);
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 20000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (disturb) begin
          start = $urandom_range(0, 1) == 1;
          in_x  = W'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, " completes"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, " result"}, 32'(result), 32'(exp_res));
      chk({tag, " op count"}, 32'(op_cnt), 32'(exp_ops));
      @(negedge clk);
      chk({tag, " done one pulse"}, 32'(done), 32'd0);
      chk({tag, " result held"}, 32'(result), 32'(exp_res));
    end
  endtask

  initial begin
    int cyc;
    logic [W-1:0] rm;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset state", 32'(dut.state_q), 32'(StIdle));
    chk("reset outputs", {15'd0, mont_start, done, result}, 32'd0);
    chk("reset operands", {mont_a, mont_b}, 32'd0);
    chk("reset modulus", 32'(mont_m), 32'd0);
    reset = 1'b0;

    run_exp("x2e5", 16'd2, 16'd5, 3, 16'd241, 1'b0);
    run_exp("e0", 16'd7, 16'd0, 0, 16'd241, 1'b0);

    stale_mode = 1'b1;
    run_exp("stale done", 16'd3, 16'hFFFF, 16, 16'd65521, 1'b0);
    stale_mode = 1'b0;

    run_exp("start ignored", 16'd2, 16'd5, 3, 16'd241, 1'b1);

    // Abort during the fourth multiplier operation.
    @(negedge clk);
    op_cnt = 0;
    load_inputs(16'd2, 16'd5, 3, 16'd241);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (op_cnt < 4 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached op 4", 32'(op_cnt >= 4), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort state", 32'(dut.state_q), 32'(StIdle));
    chk("abort outputs", {15'd0, mont_start, done, result}, 32'd0);
    chk("abort operands", {mont_a, mont_b}, 32'd0);
    chk("abort modulus", 32'(mont_m), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_exp("after abort", 16'd2, 16'd5, 3, 16'd241, 1'b0);

    run_exp("len masks high bits", 16'd2, 16'h0013, 3, 16'd241, 1'b0);

    rm = W'($urandom_range(3, 65535)) | 16'd1;
    run_exp("len clamp", W'($urandom % 32'(rm)), EW'($urandom), 20, rm, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rm         = W'($urandom_range(3, 65535)) | 16'd1;
      stale_mode = $urandom_range(0, 1) == 1;
      run_exp("random", W'($urandom % 32'(rm)), EW'($urandom), int'($urandom_range(0, 16)), rm,
              k[0]);
    end
    stale_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
